// File: rtl/retire_scheduler.sv
// retire_scheduler: in-order commit queue between COMPLETE and arch state.
// Drains retired rows to two RF write ports; sequences stores RF read -> mem write.
// Ports: i_retire_* two lanes (lane 0 older), o_retire_ready, o_w_reg_* RF writes,
//   o_r_reg_addr/i_r_reg_data store-source read, o_w_mem_* memory write,
//   o_count occupancy, o_store_busy store sequencer active.
// Option: RETIRE_BYPASS_EN sends non-store rows straight to the write ports
//   when the queue is empty and no store is in flight.
module retire_scheduler #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int PREG_W = 6
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_retire_valid    [0:1],
  input  logic                   i_retire_regwrite [0:1],
  input  logic                   i_retire_memwrite [0:1],
  input  logic [PREG_W-1:0]      i_retire_dst      [0:1],
  input  logic [DATA_W-1:0]      i_retire_data     [0:1],
  output logic                   o_retire_ready,
  output logic                   o_w_reg_en        [0:1],
  output logic [PREG_W-1:0]      o_w_reg_addr      [0:1],
  output logic [DATA_W-1:0]      o_w_reg_data      [0:1],
  output logic [PREG_W-1:0]      o_r_reg_addr,
  input  logic [DATA_W-1:0]      i_r_reg_data,
  output logic                   o_w_mem_en,
  output logic [DATA_W-1:0]      o_w_mem_addr,
  output logic [DATA_W-1:0]      o_w_mem_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_store_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic              rw;
    logic              mw;
    logic [PREG_W-1:0] dst;
    logic [DATA_W-1:0] data;
  } row_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } st_e;

  row_t              ring_q [DEPTH];
  logic [AW-1:0]     head_q, head_d;
  logic [AW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  st_e               st_q, st_d;

  logic              wen_q   [0:1];
  logic              wen_d   [0:1];
  logic [PREG_W-1:0] waddr_q [0:1];
  logic [PREG_W-1:0] waddr_d [0:1];
  logic [DATA_W-1:0] wdata_q [0:1];
  logic [DATA_W-1:0] wdata_d [0:1];
  logic [PREG_W-1:0] raddr_q, raddr_d;
  logic              men_q, men_d;
  logic [DATA_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] mdata_q, mdata_d;

  row_t              in_row [0:1];
  row_t              h0, h1;
  logic [AW-1:0]     head1, tail1;
  logic              has0, has1;
  logic              ready;
  logic              byp_ok;
  logic              byp [0:1];
  logic              enq [0:1];
  logic [1:0]        enq_n, deq_n;

  assign in_row[0] = {i_retire_regwrite[0], i_retire_memwrite[0],
                      i_retire_dst[0], i_retire_data[0]};
  assign in_row[1] = {i_retire_regwrite[1], i_retire_memwrite[1],
                      i_retire_dst[1], i_retire_data[1]};

  assign head1 = head_q + 1'b1;
  assign h0    = ring_q[head_q];
  assign h1    = ring_q[head1];
  assign has0  = count_q != '0;
  assign has1  = count_q > CW'(1);
  assign ready = count_q <= CW'(DEPTH - 2);

`ifdef RETIRE_BYPASS_EN
  assign byp_ok = (st_q == S_IDLE) && (count_q == '0);
`else
  assign byp_ok = 1'b0;
`endif

  // A lane-0 store must stay ahead of lane 1, so it blocks lane-1 bypass.
  always_comb begin
    byp[0] = byp_ok && i_retire_valid[0] && !i_retire_memwrite[0];
    byp[1] = byp_ok && i_retire_valid[1] && !i_retire_memwrite[1]
             && !(i_retire_valid[0] && i_retire_memwrite[0]);
    enq[0] = ready && i_retire_valid[0] && !byp[0];
    enq[1] = ready && i_retire_valid[1] && !byp[1];
    enq_n  = {1'b0, enq[0]} + {1'b0, enq[1]};
    tail1  = enq[0] ? tail_q + 1'b1 : tail_q;
  end

  always_comb begin
    st_d    = st_q;
    deq_n   = 2'd0;
    raddr_d = raddr_q;
    men_d   = 1'b0;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    for (int i = 0; i < 2; i++) begin
      wen_d[i]   = 1'b0;
      waddr_d[i] = waddr_q[i];
      wdata_d[i] = wdata_q[i];
    end

    unique case (st_q)
      S_IDLE: begin
        if (has0) begin
          if (h0.mw) begin
            st_d    = S_ADDR;
            raddr_d = h0.dst;
          end else begin
            deq_n      = 2'd1;
            wen_d[0]   = h0.rw;
            waddr_d[0] = h0.dst;
            wdata_d[0] = h0.data;
            if (has1 && !h1.mw) begin
              deq_n      = 2'd2;
              wen_d[1]   = h1.rw;
              waddr_d[1] = h1.dst;
              wdata_d[1] = h1.data;
            end
          end
        end
      end
      S_ADDR: st_d = S_DATA;
      S_DATA: begin
        men_d   = 1'b1;
        maddr_d = h0.data;
        mdata_d = i_r_reg_data;
        deq_n   = 2'd1;
        if (has1 && h1.mw) begin
          st_d    = S_ADDR;
          raddr_d = h1.dst;
        end else begin
          st_d = S_IDLE;
        end
      end
      default: st_d = S_IDLE;
    endcase

    for (int i = 0; i < 2; i++) begin
      if (byp[i]) begin
        wen_d[i]   = i_retire_regwrite[i];
        waddr_d[i] = i_retire_dst[i];
        wdata_d[i] = i_retire_data[i];
      end
    end

    head_d  = head_q + AW'(deq_n);
    tail_d  = tail_q + AW'(enq_n);
    count_d = count_q + CW'(enq_n) - CW'(deq_n);
  end

  always_ff @(posedge i_clk) begin
    if (enq[0]) ring_q[tail_q] <= in_row[0];
    if (enq[1]) ring_q[tail1]  <= in_row[1];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      st_q    <= S_IDLE;
      raddr_q <= '0;
      men_q   <= 1'b0;
      maddr_q <= '0;
      mdata_q <= '0;
      for (int i = 0; i < 2; i++) begin
        wen_q[i]   <= 1'b0;
        waddr_q[i] <= '0;
        wdata_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      st_q    <= st_d;
      raddr_q <= raddr_d;
      men_q   <= men_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      for (int i = 0; i < 2; i++) begin
        wen_q[i]   <= wen_d[i];
        waddr_q[i] <= waddr_d[i];
        wdata_q[i] <= wdata_d[i];
      end
    end
  end

  assign o_retire_ready = ready;
  assign o_w_reg_en     = wen_q;
  assign o_w_reg_addr   = waddr_q;
  assign o_w_reg_data   = wdata_q;
  assign o_r_reg_addr   = raddr_q;
  assign o_w_mem_en     = men_q;
  assign o_w_mem_addr   = maddr_q;
  assign o_w_mem_data   = mdata_q;
  assign o_count        = count_q;
  assign o_store_busy   = st_q != S_IDLE;

endmodule

// File: tb/tb_retire_scheduler.sv
// tb_retire_scheduler: directed + random checks of retire_scheduler
// against a program-order reference model and a local register file.
module tb_retire_scheduler;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;
  localparam int PREG_W = 6;
  localparam int CW     = $clog2(DEPTH) + 1;
`ifdef RETIRE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  typedef logic [2*DATA_W:0] ev_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              v     [0:1];
  logic              rw    [0:1];
  logic              mw    [0:1];
  logic [PREG_W-1:0] dst   [0:1];
  logic [DATA_W-1:0] dat   [0:1];
  logic              ready;
  logic              wen   [0:1];
  logic [PREG_W-1:0] waddr [0:1];
  logic [DATA_W-1:0] wdata [0:1];
  logic [PREG_W-1:0] raddr;
  logic [DATA_W-1:0] rdata = '0;
  logic              men;
  logic [DATA_W-1:0] maddr, mdata;
  logic [CW-1:0]     count;
  logic              busy;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] rf   [64] = '{default: '0};
  logic [DATA_W-1:0] arch [64] = '{default: '0};
  ev_t obs_q [$];
  ev_t exp_q [$];

  retire_scheduler #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .PREG_W(PREG_W)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_retire_valid   (v),
    .i_retire_regwrite(rw),
    .i_retire_memwrite(mw),
    .i_retire_dst     (dst),
    .i_retire_data    (dat),
    .o_retire_ready   (ready),
    .o_w_reg_en       (wen),
    .o_w_reg_addr     (waddr),
    .o_w_reg_data     (wdata),
    .o_r_reg_addr     (raddr),
    .i_r_reg_data     (rdata),
    .o_w_mem_en       (men),
    .o_w_mem_addr     (maddr),
    .o_w_mem_data     (mdata),
    .o_count          (count),
    .o_store_busy     (busy)
  );

  always #5 clk = ~clk;

  // Register file: port 1 is younger, so it wins on a same-cycle clash.
  always @(posedge clk) begin
    if (wen[0] === 1'b1) rf[waddr[0]] <= wdata[0];
    if (wen[1] === 1'b1) rf[waddr[1]] <= wdata[1];
    rdata <= rf[raddr];
  end

  always @(negedge clk) begin
    if (men === 1'b1) obs_q.push_back({1'b1, maddr, mdata});
    if (wen[0] === 1'b1) obs_q.push_back({1'b0, DATA_W'(waddr[0]), wdata[0]});
    if (wen[1] === 1'b1) obs_q.push_back({1'b0, DATA_W'(waddr[1]), wdata[1]});
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [95:0] o, input logic [95:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic idle_in();
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; rw[i] = 1'b0; mw[i] = 1'b0; dst[i] = '0; dat[i] = '0;
    end
  endtask

  task automatic drive(input int l, input logic r, input logic m,
                       input logic [PREG_W-1:0] d, input logic [DATA_W-1:0] x);
    v[l] = 1'b1; rw[l] = r; mw[l] = m; dst[l] = d; dat[l] = x;
  endtask

  // Program-order model: a store writes the architectural value of its source.
  task automatic expect_row(input logic r, input logic m,
                            input logic [PREG_W-1:0] d, input logic [DATA_W-1:0] x);
    if (m) exp_q.push_back({1'b1, x, arch[d]});
    else if (r) begin
      exp_q.push_back({1'b0, DATA_W'(d), x});
      arch[d] = x;
    end
  endtask

  task automatic drain_check(input string tag);
    int n;
    n = 0;
    idle_in();
    while ((count !== '0 || busy !== 1'b0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_bound"}, 96'(n < 300), 96'(1));
    chk({tag, "_events"}, 96'(obs_q.size()), 96'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < obs_q.size()) chk({tag, "_ev"}, 96'(obs_q[i]), 96'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int k;
    logic r_, m_;
    logic [PREG_W-1:0] d_;
    logic [DATA_W-1:0] x_, old3;

    idle_in();
    repeat (2) @(negedge clk);
    chk("rst_count", 96'(count), 96'(0));
    chk("rst_ready", 96'(ready), 96'(1));
    chk("rst_busy",  96'(busy),  96'(0));
    chk("rst_wen0",  96'(wen[0]), 96'(0));
    chk("rst_wen1",  96'(wen[1]), 96'(0));
    chk("rst_men",   96'(men),   96'(0));
    chk("rst_raddr", 96'(raddr), 96'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Dual regwrite
    drive(0, 1'b1, 1'b0, 6'd5, 32'h11); expect_row(1'b1, 1'b0, 6'd5, 32'h11);
    drive(1, 1'b1, 1'b0, 6'd6, 32'h22); expect_row(1'b1, 1'b0, 6'd6, 32'h22);
    for (int c = 1; c <= LAT + 1; c++) begin
      @(negedge clk);
      idle_in();
      chk("dual_en0", 96'(wen[0]), 96'(c == LAT));
      chk("dual_en1", 96'(wen[1]), 96'(c == LAT));
      if (c == LAT) begin
        chk("dual_a0", 96'(waddr[0]), 96'(5));
        chk("dual_d0", 96'(wdata[0]), 96'(32'h11));
        chk("dual_a1", 96'(waddr[1]), 96'(6));
        chk("dual_d1", 96'(wdata[1]), 96'(32'h22));
        chk("dual_cnt", 96'(count), 96'(0));
      end
    end
    drain_check("dual");

    // Store after a write to its source register
    drive(0, 1'b1, 1'b0, 6'd7, 32'hABCD); expect_row(1'b1, 1'b0, 6'd7, 32'hABCD);
    drive(1, 1'b0, 1'b1, 6'd7, 32'h40);   expect_row(1'b0, 1'b1, 6'd7, 32'h40);
    for (int c = 1; c <= LAT + 3; c++) begin
      @(negedge clk);
      idle_in();
      chk("st_men", 96'(men), 96'(c == LAT + 3));
      if (c == LAT) begin
        chk("st_wen0", 96'(wen[0]), 96'(1));
        chk("st_wa0",  96'(waddr[0]), 96'(7));
      end
      if (c == LAT + 3) begin
        chk("st_maddr", 96'(maddr), 96'(32'h40));
        chk("st_mdata", 96'(mdata), 96'(32'hABCD));
      end
    end
    drain_check("st_order");

    // Order barrier: store of r3 then write of r3
    old3 = arch[3];
    drive(0, 1'b0, 1'b1, 6'd3, 32'h44); expect_row(1'b0, 1'b1, 6'd3, 32'h44);
    drive(1, 1'b1, 1'b0, 6'd3, 32'h33); expect_row(1'b1, 1'b0, 6'd3, 32'h33);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      idle_in();
      chk("bar_busy", 96'(busy),   96'(c == 2 || c == 3));
      chk("bar_men",  96'(men),    96'(c == 4));
      chk("bar_wen0", 96'(wen[0]), 96'(c == 5));
      if (c == 4) chk("bar_mdata", 96'(mdata), 96'(old3));
      if (c == 5) chk("bar_wa0", 96'(waddr[0]), 96'(3));
    end
    drain_check("barrier");

    // Full: two stores per cycle until ready drops, then dropped rows
    for (int c = 0; c < 4; c++) begin
      chk("full_ready", 96'(ready), 96'(1));
      for (int l = 0; l < 2; l++) begin
        d_ = PREG_W'(5 + ((2 * c + l) % 4));
        x_ = 32'h100 + 32'(2 * c + l);
        drive(l, 1'b0, 1'b1, d_, x_);
        expect_row(1'b0, 1'b1, d_, x_);
      end
      @(negedge clk);
    end
    chk("full_cnt7", 96'(count), 96'(7));
    chk("full_nrdy", 96'(ready), 96'(0));
    drive(0, 1'b1, 1'b0, 6'd63, 32'hDEAD0000);
    drive(1, 1'b1, 1'b0, 6'd62, 32'hDEAD0001);
    @(negedge clk);
    chk("full_drop", 96'(count), 96'(7));
    drain_check("full");

    // Single row latency (bypass or queued)
    drive(0, 1'b1, 1'b0, 6'd9, 32'h5); expect_row(1'b1, 1'b0, 6'd9, 32'h5);
    @(negedge clk);
    idle_in();
    chk("lat_c1_en", 96'(wen[0]), 96'(LAT == 1));
    chk("lat_c1_cnt", 96'(count), 96'(LAT == 1 ? 0 : 1));
    @(negedge clk);
    chk("lat_c2_en", 96'(wen[0]), 96'(LAT == 2));
    drain_check("latency");

    // Random traffic with occasional protocol-violating rows
    for (int t = 0; t < 500; t++) begin
      idle_in();
      if (ready === 1'b1) begin
        for (int l = 0; l < 2; l++) begin
          if ($urandom_range(0, 9) < 6) begin
            k  = $urandom_range(0, 7);
            m_ = k < 2;
            r_ = k > 2;
            d_ = PREG_W'($urandom_range(0, 7));
            x_ = $urandom;
            drive(l, r_, m_, d_, x_);
            expect_row(r_, m_, d_, x_);
          end
        end
      end else if ($urandom_range(0, 2) == 0) begin
        drive(0, 1'b1, 1'b0, 6'd63, 32'hBAD0);
        drive(1, 1'b0, 1'b1, 6'd62, 32'hBAD1);
      end
      @(negedge clk);
    end
    drain_check("random");

    // Reset during a store's DATA cycle
    drive(0, 1'b0, 1'b1, 6'd5, 32'h80);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      idle_in();
    end
    chk("mid_busy", 96'(busy), 96'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_cnt",   96'(count), 96'(0));
    chk("mid_ready", 96'(ready), 96'(1));
    chk("mid_idle",  96'(busy),  96'(0));
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 2) rst_n = 1'b1;
      chk("mid_men", 96'(men), 96'(0));
    end
    chk("mid_cnt2", 96'(count), 96'(0));
    obs_q.delete();
    exp_q.delete();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
